// File: rtl/picomips_seq_pkg.sv
// rtl/picomips_seq_pkg.sv - shared state type, counter widths and opcode constants for the sequencer
`ifndef PICOMIPS_OPCODES_SV
`include "picomips_opcodes.sv"
`endif

package picomips_seq_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        HS_WAIT  = 2'd2
    } seq_state_t;

    localparam int MUL_CYCLES_MAX = 16;
    localparam int DEBOUNCE_MAX   = 255;

    // The wait counter holds at most MUL_CYCLES_MAX-2; the debounce counter at most DEBOUNCE_MAX-1.
    localparam int WAIT_CNT_W = $clog2(MUL_CYCLES_MAX - 1);
    localparam int DB_CNT_W   = $clog2(DEBOUNCE_MAX);

    localparam int OPC_W = `OPCODE_SIZE;

    localparam logic [OPC_W-1:0] OP_NOP   = `OP_NOP;
    localparam logic [OPC_W-1:0] OP_ADD   = `OP_ADD;
    localparam logic [OPC_W-1:0] OP_ADDI  = `OP_ADDI;
    localparam logic [OPC_W-1:0] OP_COPY  = `OP_COPY;
    localparam logic [OPC_W-1:0] OP_MULT  = `OP_MULT;
    localparam logic [OPC_W-1:0] OP_MULTI = `OP_MULTI;
    localparam logic [OPC_W-1:0] OP_WLD0  = `OP_WLD0;
    localparam logic [OPC_W-1:0] OP_WLD1  = `OP_WLD1;

endpackage

// File: rtl/picomips_opcodes.sv
// rtl/picomips_opcodes.sv - picoMIPS opcode field width and opcode encodings
`ifndef PICOMIPS_OPCODES_SV
`define PICOMIPS_OPCODES_SV

`define OPCODE_SIZE 4

`define OP_NOP   4'b0000
`define OP_ADD   4'b0001
`define OP_ADDI  4'b0010
`define OP_COPY  4'b0011
`define OP_MULT  4'b0100
`define OP_MULTI 4'b0101
`define OP_WLD0  4'b0110
`define OP_WLD1  4'b0111

`endif

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two-flop synchroniser and stable-count debouncer for the handshake switch
module switch_debouncer
    import picomips_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic Clock,
    input  logic nReset,
    input  logic raw_in,
    output logic db_out
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync1_q;
    logic                sync2_q;
    logic                db_q;
    logic                db_d;
    logic [DB_CNT_W-1:0] cnt_q;
    logic [DB_CNT_W-1:0] cnt_d;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample that agrees with the current output restarts the stability count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end
    end

    assign db_out = db_q;

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - picoMIPS program counter owner with multiplier and handshake-load stall control
module exec_sequencer
    import picomips_seq_pkg::*;
#(
    parameter int PSIZE           = 6,
    parameter int OPCODE_SIZE     = `OPCODE_SIZE,
    parameter int MUL_CYCLES      = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                   Clock,
    input  logic                   nReset,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   dec_w,
    input  logic                   handshake_switch,
    output logic [PSIZE-1:0]       pc,
    output logic                   reg_we,
    output logic                   mul_start,
    output logic                   sw_db,
    output logic                   busy,
    output logic                   illegal
);

    localparam logic [WAIT_CNT_W-1:0] MUL_LOAD = WAIT_CNT_W'(MUL_CYCLES - 2);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [PSIZE-1:0]      pc_q;
    logic [PSIZE-1:0]      pc_d;
    logic [WAIT_CNT_W-1:0] wait_q;
    logic [WAIT_CNT_W-1:0] wait_d;
    logic                  target_q;
    logic                  target_d;
    logic                  retire;
    logic                  we_c;
    logic                  start_c;
    logic                  ill_c;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .Clock (Clock),
        .nReset(nReset),
        .raw_in(handshake_switch),
        .db_out(sw_db)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= RUN;
            pc_q     <= '0;
            wait_q   <= '0;
            target_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wait_q   <= wait_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        target_d = target_q;
        retire   = 1'b0;
        we_c     = 1'b0;
        start_c  = 1'b0;
        ill_c    = 1'b0;
        case (state_q)
            RUN: begin
                case (opcode)
                    OP_MULT, OP_MULTI: begin
                        start_c = 1'b1;
                        wait_d  = MUL_LOAD;
                        state_d = MUL_WAIT;
                    end
                    // opcode[0] is the switch level each handshake load waits for.
                    OP_WLD0, OP_WLD1: begin
                        if (sw_db == opcode[0]) begin
                            we_c   = 1'b1;
                            retire = 1'b1;
                        end else begin
                            target_d = opcode[0];
                            state_d  = HS_WAIT;
                        end
                    end
                    OP_NOP, OP_ADD, OP_ADDI, OP_COPY: begin
                        we_c   = dec_w;
                        retire = 1'b1;
                    end
                    default: begin
                        ill_c  = 1'b1;
                        retire = 1'b1;
                    end
                endcase
            end
            MUL_WAIT: begin
                if (wait_q == '0) begin
                    we_c    = 1'b1;
                    retire  = 1'b1;
                    state_d = RUN;
                end else begin
                    wait_d = wait_q - WAIT_CNT_W'(1);
                end
            end
            HS_WAIT: begin
                if (sw_db == target_q) begin
                    we_c    = 1'b1;
                    retire  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign pc_d = retire ? pc_q + PSIZE'(1) : pc_q;

    // Strobes are forced low while reset is held so nothing fires from the reset-state opcode.
    assign pc        = pc_q;
    assign reg_we    = nReset & we_c;
    assign mul_start = nReset & start_c;
    assign illegal   = nReset & ill_c;
    assign busy      = (state_q != RUN);

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer
module tb_exec_sequencer;
    import picomips_seq_pkg::*;

    localparam int PW   = 6;
    localparam int MULC = 4;
    localparam int DBC  = 8;
    localparam int NPC  = 64;

    logic             Clock = 1'b0;
    logic             nReset = 1'b0;
    logic             handshake_switch = 1'b0;
    logic [OPC_W-1:0] opcode;
    logic             dec_w;
    logic [PW-1:0]    pc;
    logic             reg_we, mul_start, sw_db, busy, illegal;

    logic [OPC_W-1:0] prog [NPC];
    logic             decw [NPC];

    int checks = 0;
    int failures = 0;

    assign opcode = prog[pc];
    assign dec_w  = decw[pc];

    always #5 Clock = ~Clock;

    exec_sequencer #(
        .PSIZE(PW), .OPCODE_SIZE(OPC_W), .MUL_CYCLES(MULC), .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .Clock(Clock), .nReset(nReset), .opcode(opcode), .dec_w(dec_w),
        .handshake_switch(handshake_switch), .pc(pc), .reg_we(reg_we),
        .mul_start(mul_start), .sw_db(sw_db), .busy(busy), .illegal(illegal)
    );

    typedef struct {
        logic [OPC_W-1:0] op;
        logic             dw;
        logic             we;
        logic             ms;
        logic             ill;
        int               pc_next;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge Clock);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < NPC; i++) begin
            prog[i] = OP_NOP;
            decw[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        nReset = 1'b0;
        handshake_switch = 1'b0;
        repeat (3) @(negedge Clock);
        nReset = 1'b1;
        #1;
    endtask

    task automatic run_to_pc(input int target, input int budget);
        int n;
        n = 0;
        while (int'(pc) != target && n < budget) begin
            cyc();
            n++;
        end
        chk("reach_pc", int'(pc), target);
    endtask

    // Reference model state: instruction-level timeline plus switch history.
    int   m_pc, m_k, m_streak;
    logic m_db, p1, p2;

    task automatic model_cycle();
        logic [OPC_W-1:0] op;
        logic e_we, e_ms, e_ill, e_busy, ret, nraw, s;
        op = prog[m_pc];
        e_we = 1'b0; e_ms = 1'b0; e_ill = 1'b0; ret = 1'b0;
        e_busy = (m_k > 0);
        if (op == OP_MULT || op == OP_MULTI) begin
            e_ms = (m_k == 0);
            if (m_k == MULC - 1) begin e_we = 1'b1; ret = 1'b1; end
        end else if (op == OP_WLD0 || op == OP_WLD1) begin
            if (m_db == op[0]) begin e_we = 1'b1; ret = 1'b1; end
        end else if (op == OP_NOP || op == OP_ADD || op == OP_ADDI || op == OP_COPY) begin
            e_we = decw[m_pc];
            ret  = 1'b1;
        end else begin
            e_ill = 1'b1;
            ret   = 1'b1;
        end
        chk("rnd_pc", int'(pc), m_pc);
        chk("rnd_reg_we", int'(reg_we), int'(e_we));
        chk("rnd_mul_start", int'(mul_start), int'(e_ms));
        chk("rnd_busy", int'(busy), int'(e_busy));
        chk("rnd_illegal", int'(illegal), int'(e_ill));
        chk("rnd_sw_db", int'(sw_db), int'(m_db));
        if (ret) begin
            m_pc = (m_pc + 1) % NPC;
            m_k  = 0;
        end else begin
            m_k++;
        end
        nraw = ($urandom_range(0, 9) == 0) ? ~handshake_switch : handshake_switch;
        handshake_switch = nraw;
        // The debounced level flips after DBC consecutive synchronised samples disagree with it.
        s = p2;
        if (s != m_db) m_streak++;
        else m_streak = 0;
        if (m_streak == DBC) begin
            m_db = ~m_db;
            m_streak = 0;
        end
        p2 = p1;
        p1 = nraw;
    endtask

    initial begin
        int we_seen;

        vecs[0]  = '{OP_NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{OP_NOP,   1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{OP_ADD,   1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[3]  = '{OP_ADD,   1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{OP_ADDI,  1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{OP_COPY,  1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{OP_MULT,  1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[7]  = '{OP_MULTI, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        vecs[8]  = '{OP_WLD0,  1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{OP_WLD1,  1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{4'd8,     1'b1, 1'b0, 1'b0, 1'b1, 1};
        vecs[11] = '{4'd15,    1'b1, 1'b0, 1'b0, 1'b1, 1};

        // Reset state, with a write-requesting instruction at pc 0.
        fill_nop();
        prog[0] = OP_ADD;
        decw[0] = 1'b1;
        repeat (3) @(negedge Clock);
        #1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_reg_we", int'(reg_we), 0);
        chk("rst_mul_start", int'(mul_start), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_sw_db", int'(sw_db), 0);

        foreach (vecs[i]) begin
            fill_nop();
            prog[0] = vecs[i].op;
            decw[0] = vecs[i].dw;
            do_reset();
            chk($sformatf("vec%0d_reg_we", i), int'(reg_we), int'(vecs[i].we));
            chk($sformatf("vec%0d_mul_start", i), int'(mul_start), int'(vecs[i].ms));
            chk($sformatf("vec%0d_illegal", i), int'(illegal), int'(vecs[i].ill));
            chk($sformatf("vec%0d_busy", i), int'(busy), 0);
            cyc();
            chk($sformatf("vec%0d_pc", i), int'(pc), vecs[i].pc_next);
        end

        // NOP, ADD, NOP straight-line run.
        fill_nop();
        prog[1] = OP_ADD;
        decw[1] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", int'(pc), i);
            chk("seq_reg_we", int'(reg_we), (i == 1) ? 1 : 0);
            cyc();
        end

        // MULT at pc 3 spans MULC cycles with the write in the last.
        fill_nop();
        prog[3] = OP_MULT;
        do_reset();
        run_to_pc(3, 10);
        for (int c = 0; c < MULC; c++) begin
            chk("mul_start", int'(mul_start), (c == 0) ? 1 : 0);
            chk("mul_busy", int'(busy), (c > 0) ? 1 : 0);
            chk("mul_reg_we", int'(reg_we), (c == MULC - 1) ? 1 : 0);
            chk("mul_pc_hold", int'(pc), 3);
            cyc();
        end
        chk("mul_pc_after", int'(pc), 4);
        chk("mul_busy_after", int'(busy), 0);

        // WLD1 at pc 2 released by a clean switch edge DBC+2 cycles later.
        fill_nop();
        prog[2] = OP_WLD1;
        do_reset();
        run_to_pc(2, 10);
        chk("wld_first_busy", int'(busy), 0);
        chk("wld_first_we", int'(reg_we), 0);
        repeat (3) begin
            cyc();
            chk("wld_wait_busy", int'(busy), 1);
        end
        handshake_switch = 1'b1;
        for (int c = 0; c <= DBC + 2; c++) begin
            chk("wld_sw_db", int'(sw_db), (c == DBC + 2) ? 1 : 0);
            chk("wld_reg_we", int'(reg_we), (c == DBC + 2) ? 1 : 0);
            chk("wld_pc_hold", int'(pc), 2);
            cyc();
        end
        chk("wld_pc_after", int'(pc), 3);
        chk("wld_busy_after", int'(busy), 0);

        // Glitches of 3 and DBC-1 cycles during HS_WAIT must not release it.
        fill_nop();
        prog[2] = OP_WLD1;
        do_reset();
        run_to_pc(2, 10);
        we_seen = 0;
        foreach (vecs[g]) begin
            if (g < 2) begin
                handshake_switch = 1'b1;
                repeat ((g == 0) ? 3 : DBC - 1) begin
                    cyc();
                    we_seen += int'(reg_we);
                end
                handshake_switch = 1'b0;
                repeat (DBC + 4) begin
                    cyc();
                    we_seen += int'(reg_we);
                    chk("glitch_sw_db", int'(sw_db), 0);
                end
                chk("glitch_pc", int'(pc), 2);
                chk("glitch_busy", int'(busy), 1);
            end
        end
        chk("glitch_no_write", we_seen, 0);

        // pc wrap from 63 and an unknown opcode at pc 0.
        fill_nop();
        prog[NPC-1] = OP_ADD;
        decw[NPC-1] = 1'b1;
        do_reset();
        run_to_pc(NPC - 1, 80);
        prog[0] = 4'd10;
        decw[0] = 1'b1;
        chk("wrap_reg_we", int'(reg_we), 1);
        cyc();
        chk("wrap_pc", int'(pc), 0);
        chk("ill_flag", int'(illegal), 1);
        chk("ill_reg_we", int'(reg_we), 0);
        cyc();
        chk("ill_pc_after", int'(pc), 1);
        chk("ill_one_cycle", int'(illegal), 0);

        // Reset during MUL_WAIT at pc 5 abandons the multiply without a write.
        fill_nop();
        prog[5] = OP_MULT;
        do_reset();
        run_to_pc(5, 10);
        we_seen = int'(reg_we);
        repeat (2) begin
            cyc();
            we_seen += int'(reg_we);
        end
        chk("mrst_busy_before", int'(busy), 1);
        nReset = 1'b0;
        #1;
        chk("mrst_pc", int'(pc), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_reg_we", int'(reg_we), 0);
        chk("mrst_no_write", we_seen, 0);
        cyc();
        nReset = 1'b1;
        #1;
        chk("mrst_pc_release", int'(pc), 0);

        // Randomised program and switch activity against the reference model.
        for (int i = 0; i < NPC; i++) begin
            prog[i] = OPC_W'($urandom_range(0, 15));
            decw[i] = 1'($urandom_range(0, 1));
        end
        do_reset();
        m_pc = 0; m_k = 0; m_streak = 0;
        m_db = 1'b0; p1 = 1'b0; p2 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            model_cycle();
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
